// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Forwarding and hazard controller for the 5-stage pipeline.
//   - Per-operand EX forwarding select (MEM over WB, x0 never forwards).
//   - Load-use stall engine inserting LOAD_STALL bubbles.
//   - Data-memory wait hold that freezes the load-use engine.
//   Optional build macro: HFC_PERF_CNT_EN adds saturating stall/wait counters;
//   without it the perf ports are tied to zero.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_rs_id / i_rs_id_used     ID source indices and per-operand read flags
//   i_rs_ex                    EX source indices
//   i_rd_ex, i_mem_read_ex     EX destination and load flag
//   i_flush_ex                 taken branch/jump resolved in EX
//   i_rd_mem, i_register_write_mem, i_mem_read_mem, i_dmem_ready   MEM stage
//   i_rd_wb, i_register_write_wb                                   WB stage
//   o_forward_sel              2 bits per operand: 00 regfile, 10 MEM, 01 WB
//   o_stall_if_id, o_bubble_id_ex, o_hold_ex_mem, o_bubble_mem_wb  pipeline control
//   o_perf_stall_cnt, o_perf_wait_cnt                              perf counters
module hazard_forward_ctrl #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]   i_rs_id,
    input  logic [NUM_SRC-1:0]          i_rs_id_used,
    input  logic [NUM_SRC*REG_AW-1:0]   i_rs_ex,
    input  logic [REG_AW-1:0]           i_rd_ex,
    input  logic                        i_mem_read_ex,
    input  logic                        i_flush_ex,
    input  logic [REG_AW-1:0]           i_rd_mem,
    input  logic                        i_register_write_mem,
    input  logic                        i_mem_read_mem,
    input  logic                        i_dmem_ready,
    input  logic [REG_AW-1:0]           i_rd_wb,
    input  logic                        i_register_write_wb,
    output logic [NUM_SRC*2-1:0]        o_forward_sel,
    output logic                        o_stall_if_id,
    output logic                        o_bubble_id_ex,
    output logic                        o_hold_ex_mem,
    output logic                        o_bubble_mem_wb,
    output logic [CNT_W-1:0]            o_perf_stall_cnt,
    output logic [CNT_W-1:0]            o_perf_wait_cnt
);

    localparam int unsigned    CW         = 3;
    localparam logic [0:0]     S_IDLE     = 1'b0;
    localparam logic [0:0]     S_STALL    = 1'b1;
    localparam bit             MULTI      = (LOAD_STALL > 1);
    localparam logic [CW-1:0]  STALL_INIT = CW'(LOAD_STALL - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [REG_AW-1:0]   w_src;
    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic                w_hit_any;
    logic                w_hit;
    logic                w_mem_wait;
    logic                w_lu_active;

    // Forwarding select per EX operand; MEM beats WB, loads in MEM cannot forward yet.
    always_comb begin
        w_fwd_sel = '0;
        w_src     = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            w_src = i_rs_ex[i*REG_AW +: REG_AW];
            if ((w_src != '0) && i_register_write_mem && !i_mem_read_mem && (w_src == i_rd_mem)) begin
                w_fwd_sel[i*2 +: 2] = 2'b10;
            end else if ((w_src != '0) && i_register_write_wb && (w_src == i_rd_wb)) begin
                w_fwd_sel[i*2 +: 2] = 2'b01;
            end
        end
    end

    assign o_forward_sel = w_fwd_sel;

    // Load-use hazard: a used ID operand reads the register a load in EX produces.
    always_comb begin
        w_hit_any = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (i_rs_id_used[i] && (i_rs_id[i*REG_AW +: REG_AW] == i_rd_ex)) begin
                w_hit_any = 1'b1;
            end
        end
    end

    assign w_hit      = i_mem_read_ex && (i_rd_ex != '0) && w_hit_any;
    assign w_mem_wait = i_mem_read_mem && !i_dmem_ready;

    // Load-use engine: flush clears it, a memory wait freezes it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lu_active = 1'b0;
        if (i_flush_ex) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        w_lu_active = 1'b1;
                        if (!w_mem_wait && MULTI) begin
                            w_state_nxt = S_STALL;
                            w_cnt_nxt   = STALL_INIT;
                        end
                    end
                end
                S_STALL: begin
                    w_lu_active = 1'b1;
                    if (!w_mem_wait) begin
                        if (r_cnt == CW'(1)) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Control outputs are forced low while reset is asserted; ID/EX is held, not bubbled, during a wait.
    assign o_stall_if_id   = rst_n && (w_lu_active || w_mem_wait);
    assign o_bubble_id_ex  = rst_n && w_lu_active && !w_mem_wait;
    assign o_hold_ex_mem   = rst_n && w_mem_wait;
    assign o_bubble_mem_wb = rst_n && w_mem_wait;

`ifdef HFC_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_wait;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_wait  <= '0;
        end else begin
            if (o_bubble_id_ex && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            end
            if (o_hold_ex_mem && (r_perf_wait != '1)) begin
                r_perf_wait <= r_perf_wait + CNT_W'(1);
            end
        end
    end

    assign o_perf_stall_cnt = r_perf_stall;
    assign o_perf_wait_cnt  = r_perf_wait;
`else
    assign o_perf_stall_cnt = '0;
    assign o_perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (LOAD_STALL 1 and 3) share stimulus;
// a remaining-bubble model checks every cycle, directed literals pin the scenarios.
module tb_hazard_forward_ctrl;

    localparam int unsigned NS = 2;
    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NS*AW-1:0] rs_id, rs_ex;
    logic [NS-1:0]    used;
    logic [AW-1:0]    rd_ex, rd_mem, rd_wb;
    logic             mre, flush, rwm, mrm, rdy, rww;

    logic [2*NS-1:0]  fs [2];
    logic             st [2];
    logic             bi [2];
    logic             hd [2];
    logic             bm [2];
    logic [31:0]      ps1, pw1;
    logic [3:0]       ps3, pw3;

    int     n_checks = 0;
    int     n_errors = 0;
    int     pend [2];
    longint pst [2];
    longint pwt [2];
    int     ls [2]   = '{1, 3};
    longint pmax [2] = '{64'hFFFF_FFFF, 64'd15};

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_STALL(1), .CNT_W(32)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_rs_id(rs_id), .i_rs_id_used(used), .i_rs_ex(rs_ex),
        .i_rd_ex(rd_ex), .i_mem_read_ex(mre), .i_flush_ex(flush),
        .i_rd_mem(rd_mem), .i_register_write_mem(rwm), .i_mem_read_mem(mrm),
        .i_dmem_ready(rdy), .i_rd_wb(rd_wb), .i_register_write_wb(rww),
        .o_forward_sel(fs[0]), .o_stall_if_id(st[0]), .o_bubble_id_ex(bi[0]),
        .o_hold_ex_mem(hd[0]), .o_bubble_mem_wb(bm[0]),
        .o_perf_stall_cnt(ps1), .o_perf_wait_cnt(pw1)
    );

    hazard_forward_ctrl #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_STALL(3), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n),
        .i_rs_id(rs_id), .i_rs_id_used(used), .i_rs_ex(rs_ex),
        .i_rd_ex(rd_ex), .i_mem_read_ex(mre), .i_flush_ex(flush),
        .i_rd_mem(rd_mem), .i_register_write_mem(rwm), .i_mem_read_mem(mrm),
        .i_dmem_ready(rdy), .i_rd_wb(rd_wb), .i_register_write_wb(rww),
        .o_forward_sel(fs[1]), .o_stall_if_id(st[1]), .o_bubble_id_ex(bi[1]),
        .o_hold_ex_mem(hd[1]), .o_bubble_mem_wb(bm[1]),
        .o_perf_stall_cnt(ps3), .o_perf_wait_cnt(pw3)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Forwarding rule straight from the operand-match definition.
    function automatic logic [2*NS-1:0] exp_fwd();
        logic [2*NS-1:0] r = '0;
        logic [AW-1:0]   s;
        for (int i = 0; i < int'(NS); i++) begin
            s = rs_ex[i*AW +: AW];
            if (s != 0 && rwm && !mrm && s == rd_mem) r[i*2 +: 2] = 2'b10;
            else if (s != 0 && rww && s == rd_wb)     r[i*2 +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic bit exp_hit();
        bit any = 1'b0;
        for (int i = 0; i < int'(NS); i++)
            if (used[i] && rs_id[i*AW +: AW] == rd_ex) any = 1'b1;
        return mre && (rd_ex != 0) && any;
    endfunction

    // Per-cycle compare against a "bubbles still owed" model.
    always @(negedge clk) begin
        bit     hit, wt, lu;
        longint ps_a, pw_a;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                pend[k] = 0; pst[k] = 0; pwt[k] = 0;
            end
        end
        hit = exp_hit();
        wt  = mrm && !rdy;
        for (int k = 0; k < 2; k++) begin
            lu = rst_n && !flush && (pend[k] > 0 || hit);
            check($sformatf("u%0d.forward_sel", ls[k]), longint'(fs[k]), longint'(exp_fwd()));
            check($sformatf("u%0d.stall_if_id", ls[k]), longint'(st[k]), longint'(lu || (wt && rst_n)));
            check($sformatf("u%0d.bubble_id_ex", ls[k]), longint'(bi[k]), longint'(lu && !wt));
            check($sformatf("u%0d.hold_ex_mem", ls[k]), longint'(hd[k]), longint'(wt && rst_n));
            check($sformatf("u%0d.bubble_mem_wb", ls[k]), longint'(bm[k]), longint'(wt && rst_n));
            ps_a = (k == 0) ? longint'(ps1) : longint'(ps3);
            pw_a = (k == 0) ? longint'(pw1) : longint'(pw3);
`ifdef HFC_PERF_CNT_EN
            check($sformatf("u%0d.perf_stall_cnt", ls[k]), ps_a, pst[k]);
            check($sformatf("u%0d.perf_wait_cnt", ls[k]), pw_a, pwt[k]);
`else
            check($sformatf("u%0d.perf_stall_cnt", ls[k]), ps_a, 0);
            check($sformatf("u%0d.perf_wait_cnt", ls[k]), pw_a, 0);
`endif
            if (rst_n) begin
                if (lu && !wt && pst[k] < pmax[k]) pst[k]++;
                if (wt && rst_n && pwt[k] < pmax[k]) pwt[k]++;
                if (flush)            pend[k] = 0;
                else if (!wt) begin
                    if (pend[k] > 0)  pend[k]--;
                    else if (hit)     pend[k] = ls[k] - 1;
                end
            end
        end
    end

    task automatic clear();
        rs_id = '0; rs_ex = '0; used = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
        mre = 1'b0; flush = 1'b0; rwm = 1'b0; mrm = 1'b0; rdy = 1'b1; rww = 1'b0;
    endtask

    task automatic hazard();
        rd_ex = 5'd7; mre = 1'b1; rs_id = {5'd0, 5'd7}; used = 2'b01;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b1, b3;
        logic [1:0] sel1;
        clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Forwarding priority and x0 exclusion on operand 1.
        step(); rs_ex = {5'd5, 5'd0}; rd_mem = 5'd5; rwm = 1'b1; rd_wb = 5'd5; rww = 1'b1;
        #1 sel1 = fs[0][3:2]; check("t1_mem_sel", longint'(sel1), 2);
        step(); rwm = 1'b0;
        #1 sel1 = fs[0][3:2]; check("t1_wb_sel", longint'(sel1), 1);
        step(); rs_ex = '0;
        #1 sel1 = fs[0][3:2]; check("t1_x0_sel", longint'(sel1), 0);

        // Load-use with 1 and 3 bubbles.
        step(); clear(); hazard();
        #1 check("t2_u1_stall", longint'(st[0]), 1); check("t2_u1_bubble", longint'(bi[0]), 1);
        b1 = int'(bi[0]); b3 = int'(bi[1]);
        for (int c = 0; c < 4; c++) begin
            step(); clear();
            #1 b1 += int'(bi[0]); b3 += int'(bi[1]);
        end
        check("t2_u1_bubbles", b1, 1);
        check("t3_u3_bubbles", b3, 3);
`ifdef HFC_PERF_CNT_EN
        check("t3_u3_perf_stall", longint'(ps3), 3);
`endif
        step(); hazard(); used = 2'b00;
        #1 check("t2_unused_u1", longint'(st[0]), 0); check("t2_unused_u3", longint'(st[1]), 0);

        // Flush in detect cycle and mid-sequence.
        step(); clear(); hazard(); flush = 1'b1;
        #1 check("t4_flush_u1", longint'(st[0]), 0); check("t4_flush_u3", longint'(st[1]), 0);
        step(); clear(); hazard();
        #1 check("t4_start_u3", longint'(bi[1]), 1);
        step(); clear(); flush = 1'b1;
        #1 check("t4_mid_flush_u3", longint'(st[1]), 0);
        step(); clear();
        #1 check("t4_idle_u3", longint'(st[1]), 0);

        // Memory wait in the middle of a 3-bubble sequence.
        step(); clear(); hazard();
        #1 b3 = int'(bi[1]);
        for (int c = 0; c < 4; c++) begin
            step(); clear(); mrm = 1'b1; rdy = 1'b0;
            #1 check("t5_hold", longint'(hd[1]), 1);
            check("t5_no_bubble", longint'(bi[1]), 0);
            check("t5_bmw", longint'(bm[1]), 1);
        end
        for (int c = 0; c < 4; c++) begin
            step(); clear();
            #1 b3 += int'(bi[1]);
        end
        check("t5_total_bubbles", b3, 3);

        // Asynchronous reset during STALL.
        step(); clear(); hazard();
        step(); clear();
        #1 check("t6_in_stall", longint'(st[1]), 1);
        #1 rst_n = 1'b0;
        #1 check("t6_rst_stall", longint'(st[1]), 0); check("t6_rst_bubble", longint'(bi[1]), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        #1 check("t6_post_u1", longint'(st[0]), 0); check("t6_post_u3", longint'(st[1]), 0);
`ifdef HFC_PERF_CNT_EN
        check("t6_perf_stall", longint'(ps3), 0); check("t6_perf_wait", longint'(pw3), 0);
`endif

        // Randomized traffic with small register indices for frequent matches.
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < int'(NS); i++) begin
                rs_id[i*AW +: AW] = AW'($urandom_range(0, 3));
                rs_ex[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            used   = NS'($urandom_range(0, 3));
            rd_ex  = AW'($urandom_range(0, 3));
            rd_mem = AW'($urandom_range(0, 3));
            rd_wb  = AW'($urandom_range(0, 3));
            mre    = 1'($urandom_range(0, 1));
            rwm    = 1'($urandom_range(0, 1));
            rww    = 1'($urandom_range(0, 1));
            mrm    = 1'($urandom_range(0, 1));
            rdy    = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 15) == 0);
        end
        step(); clear();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
